// File: rtl/energy_monitor.sv
// Ising energy engine: latches a spin vector, accumulates one signed contribution
// per streamed weight row, and returns the (optionally negated) Hamiltonian.
`timescale 1ns/1ps
module energy_monitor #(
    parameter int unsigned NUM_SPIN      = 256,
    parameter int unsigned BITJ          = 4,
    parameter int unsigned BITH          = 4,
    parameter int unsigned SCALING_BIT   = 4,
    parameter int unsigned ENERGY_W      = 32,
    parameter bit          LITTLE_ENDIAN = 1'b1,
    parameter bit          H_IS_NEGATIVE = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       spin_valid_i,
    output logic                       spin_ready_o,
    input  logic [NUM_SPIN-1:0]        spin_i,
    input  logic [SCALING_BIT-1:0]     hscaling_i,
    input  logic                       weight_valid_i,
    output logic                       weight_ready_o,
    input  logic [NUM_SPIN*BITJ-1:0]   weight_i,
    input  logic [BITH-1:0]            hbias_i,
    output logic                       energy_valid_o,
    input  logic                       energy_ready_i,
    output logic [ENERGY_W-1:0]        energy_o,
    output logic                       busy_o
);

    localparam int unsigned CNT_W = (NUM_SPIN > 1) ? $clog2(NUM_SPIN) : 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(NUM_SPIN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [NUM_SPIN-1:0]     spin_q, spin_d;
    logic [SCALING_BIT-1:0]  hscale_q, hscale_d;
    logic [CNT_W-1:0]        row_q, row_d;
    logic [ENERGY_W-1:0]     acc_q, acc_d;
    logic [ENERGY_W-1:0]     contrib_q, contrib_d;
    logic                    pipe_vld_q, pipe_vld_d;
    logic                    spin_ready_q, spin_ready_d;
    logic                    weight_ready_q, weight_ready_d;
    logic                    energy_valid_q, energy_valid_d;
    logic [ENERGY_W-1:0]     energy_q, energy_d;
    logic                    busy_q, busy_d;

    logic                    spin_hs, weight_hs, result_hs;
    logic [BITJ-1:0]         w_raw;
    logic [ENERGY_W-1:0]     w_ext;
    logic [ENERGY_W-1:0]     col_sum;
    logic [ENERGY_W-1:0]     h_ext;
    logic [ENERGY_W-1:0]     hs_ext;
    logic [ENERGY_W-1:0]     local_sum;
    logic                    row_spin;
    logic [ENERGY_W-1:0]     row_contrib;

    // Row contribution; all arithmetic wraps modulo 2^ENERGY_W, so unsigned ops on
    // sign-extended operands give the two's-complement result directly.
    always_comb begin : row_calc
        w_raw   = '0;
        w_ext   = '0;
        col_sum = '0;
        for (int j = 0; j < int'(NUM_SPIN); j++) begin
            w_raw   = weight_i[j*BITJ +: BITJ];
            w_ext   = {{(ENERGY_W-BITJ){w_raw[BITJ-1]}}, w_raw};
            col_sum = spin_q[j] ? (col_sum + w_ext) : (col_sum - w_ext);
        end
        h_ext     = {{(ENERGY_W-BITH){hbias_i[BITH-1]}}, hbias_i};
        hs_ext    = {{(ENERGY_W-SCALING_BIT){1'b0}}, hscale_q};
        local_sum = col_sum + (h_ext * hs_ext);
        row_spin  = LITTLE_ENDIAN ? spin_q[row_q] : spin_q[LAST_ROW - row_q];
        row_contrib = row_spin ? local_sum : (ENERGY_W'(0) - local_sum);
    end

    assign spin_hs   = spin_valid_i & spin_ready_q & (state_q == IDLE);
    assign weight_hs = weight_valid_i & weight_ready_q & (state_q == ACCUM);
    assign result_hs = energy_valid_q & energy_ready_i;

    // Next-state and registered-output logic
    always_comb begin : fsm_comb
        state_d        = state_q;
        spin_d         = spin_q;
        hscale_d       = hscale_q;
        row_d          = row_q;
        contrib_d      = contrib_q;
        pipe_vld_d     = 1'b0;
        acc_d          = pipe_vld_q ? (acc_q + contrib_q) : acc_q;
        energy_d       = energy_q;

        unique case (state_q)
            IDLE: begin
                if (spin_hs) begin
                    spin_d   = spin_i;
                    hscale_d = hscaling_i;
                    row_d    = '0;
                    acc_d    = '0;
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                if (weight_hs) begin
                    contrib_d  = row_contrib;
                    pipe_vld_d = 1'b1;
                    row_d      = row_q + CNT_W'(1);
                    if (row_q == LAST_ROW) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                if (result_hs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        spin_ready_d   = (state_d == IDLE);
        weight_ready_d = (state_d == ACCUM);
        busy_d         = (state_d != IDLE);
        // Result appears one cycle after DONE is entered and is held until taken
        energy_valid_d = (state_q == DONE) & ~result_hs;
        if ((state_q == DONE) && !energy_valid_q) begin
            energy_d = H_IS_NEGATIVE ? (ENERGY_W'(0) - acc_q) : acc_q;
        end
    end

    always_ff @(posedge clk_i) begin : regs
        if (!rst_ni) begin
            state_q        <= IDLE;
            spin_q         <= '0;
            hscale_q       <= '0;
            row_q          <= '0;
            acc_q          <= '0;
            contrib_q      <= '0;
            pipe_vld_q     <= 1'b0;
            spin_ready_q   <= 1'b0;
            weight_ready_q <= 1'b0;
            energy_valid_q <= 1'b0;
            energy_q       <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            spin_q         <= spin_d;
            hscale_q       <= hscale_d;
            row_q          <= row_d;
            acc_q          <= acc_d;
            contrib_q      <= contrib_d;
            pipe_vld_q     <= pipe_vld_d;
            spin_ready_q   <= spin_ready_d;
            weight_ready_q <= weight_ready_d;
            energy_valid_q <= energy_valid_d;
            energy_q       <= energy_d;
            busy_q         <= busy_d;
        end
    end

    assign spin_ready_o   = spin_ready_q;
    assign weight_ready_o = weight_ready_q;
    assign energy_valid_o = energy_valid_q;
    assign energy_o       = energy_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_energy_monitor.sv
// Bench for energy_monitor: two instances (row pairing little/big endian) share
// stimulus and are compared every cycle against a transaction-level energy model.
`timescale 1ns/1ps
module tb_energy_monitor;

    localparam int unsigned N  = 4;
    localparam int unsigned BJ = 4;
    localparam int unsigned BH = 4;
    localparam int unsigned SB = 4;
    localparam int unsigned EW = 32;

    typedef logic [N*BJ-1:0] wrows_t [N];
    typedef logic [BH-1:0]   hrows_t [N];
    typedef int              gaps_t  [N];

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              spin_valid_i = 1'b0;
    logic [N-1:0]      spin_i = '0;
    logic [SB-1:0]     hscaling_i = '0;
    logic              weight_valid_i = 1'b0;
    logic [N*BJ-1:0]   weight_i = '0;
    logic [BH-1:0]     hbias_i = '0;
    logic              energy_ready_i = 1'b0;

    logic              spin_ready_o, weight_ready_o, energy_valid_o, busy_o;
    logic [EW-1:0]     energy_o;
    logic              spin_ready_b, weight_ready_b, energy_valid_b, busy_b;
    logic [EW-1:0]     energy_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    energy_monitor #(.NUM_SPIN(N), .BITJ(BJ), .BITH(BH), .SCALING_BIT(SB), .ENERGY_W(EW),
                     .LITTLE_ENDIAN(1'b1), .H_IS_NEGATIVE(1'b1)) u_le1 (
        .clk_i(clk), .rst_ni(rst_ni),
        .spin_valid_i(spin_valid_i), .spin_ready_o(spin_ready_o),
        .spin_i(spin_i), .hscaling_i(hscaling_i),
        .weight_valid_i(weight_valid_i), .weight_ready_o(weight_ready_o),
        .weight_i(weight_i), .hbias_i(hbias_i),
        .energy_valid_o(energy_valid_o), .energy_ready_i(energy_ready_i),
        .energy_o(energy_o), .busy_o(busy_o)
    );

    energy_monitor #(.NUM_SPIN(N), .BITJ(BJ), .BITH(BH), .SCALING_BIT(SB), .ENERGY_W(EW),
                     .LITTLE_ENDIAN(1'b0), .H_IS_NEGATIVE(1'b1)) u_le0 (
        .clk_i(clk), .rst_ni(rst_ni),
        .spin_valid_i(spin_valid_i), .spin_ready_o(spin_ready_b),
        .spin_i(spin_i), .hscaling_i(hscaling_i),
        .weight_valid_i(weight_valid_i), .weight_ready_o(weight_ready_b),
        .weight_i(weight_i), .hbias_i(hbias_i),
        .energy_valid_o(energy_valid_b), .energy_ready_i(energy_ready_i),
        .energy_o(energy_b), .busy_o(busy_b)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out at %0t", name, $time);
    endfunction

    // Energy contribution of one row: s_r * (h_r*hs + sum_j sigma_j*w_rj), sigma in {-1,+1}
    function automatic longint row_value(input logic [N-1:0] sp, input logic [N*BJ-1:0] w,
                                         input logic [BH-1:0] h, input logic [SB-1:0] hs,
                                         input int row_idx);
        logic signed [BJ-1:0] wj;
        logic signed [BH-1:0] hsgn;
        longint v;
        longint wv;
        hsgn = h;
        v = longint'(hsgn) * longint'(hs);
        for (int j = 0; j < int'(N); j++) begin
            wj = w[j*BJ +: BJ];
            wv = longint'(wj);
            v += sp[j] ? wv : -wv;
        end
        return sp[row_idx] ? v : -v;
    endfunction

    // Transaction model: mode 0 waiting for spins, 1 taking rows, 2 settling, 3 result held
    int            m_mode = 0;
    int            m_rows = 0;
    int            m_settle = 0;
    logic [N-1:0]  m_spin = '0;
    logic [SB-1:0] m_hs = '0;
    longint        m_sum [2];
    logic          e_spin_rdy = 1'b0, e_w_rdy = 1'b0, e_busy = 1'b0, e_valid = 1'b0;
    logic [EW-1:0] e_energy [2];
    bit            started = 1'b0;

    always @(posedge clk) begin
        started = 1'b1;
        if (!rst_ni) begin
            m_mode = 0; m_rows = 0; m_settle = 0;
            e_spin_rdy = 1'b0; e_w_rdy = 1'b0; e_busy = 1'b0; e_valid = 1'b0;
            e_energy[0] = '0; e_energy[1] = '0;
        end else begin
            if (m_mode == 3) begin
                if (e_valid && energy_ready_i) begin
                    m_mode = 0;
                    e_valid = 1'b0;
                end
            end else if (m_mode == 2) begin
                m_settle--;
                if (m_settle == 0) begin
                    m_mode = 3;
                    e_valid = 1'b1;
                    e_energy[0] = EW'(-m_sum[0]);
                    e_energy[1] = EW'(-m_sum[1]);
                end
            end else if (m_mode == 1) begin
                if (weight_valid_i && e_w_rdy) begin
                    m_sum[0] += row_value(m_spin, weight_i, hbias_i, m_hs, m_rows);
                    m_sum[1] += row_value(m_spin, weight_i, hbias_i, m_hs, int'(N) - 1 - m_rows);
                    m_rows++;
                    if (m_rows == int'(N)) begin
                        m_mode = 2;
                        m_settle = 2;
                    end
                end
            end else begin
                if (spin_valid_i && e_spin_rdy) begin
                    m_spin = spin_i;
                    m_hs = hscaling_i;
                    m_sum[0] = 0;
                    m_sum[1] = 0;
                    m_rows = 0;
                    m_mode = 1;
                end
            end
            e_spin_rdy = (m_mode == 0);
            e_w_rdy    = (m_mode == 1);
            e_busy     = (m_mode != 0);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("spin_ready_le1",   32'(spin_ready_o),   32'(e_spin_rdy));
            check("weight_ready_le1", 32'(weight_ready_o), 32'(e_w_rdy));
            check("busy_le1",         32'(busy_o),         32'(e_busy));
            check("valid_le1",        32'(energy_valid_o), 32'(e_valid));
            check("spin_ready_le0",   32'(spin_ready_b),   32'(e_spin_rdy));
            check("weight_ready_le0", 32'(weight_ready_b), 32'(e_w_rdy));
            check("busy_le0",         32'(busy_b),         32'(e_busy));
            check("valid_le0",        32'(energy_valid_b), 32'(e_valid));
            if (e_valid) begin
                check("energy_le1", energy_o, e_energy[0]);
                check("energy_le0", energy_b, e_energy[1]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_spin(input logic [N-1:0] s, input logic [SB-1:0] hs);
        int n = 0;
        spin_i = s;
        hscaling_i = hs;
        spin_valid_i = 1'b1;
        while (!spin_ready_o && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) timeout("spin_handshake");
        tick();
        spin_valid_i = 1'b0;
        spin_i = N'($urandom);
    endtask

    task automatic do_row(input logic [N*BJ-1:0] w, input logic [BH-1:0] h, input int gap);
        int n = 0;
        repeat (gap) tick();
        weight_i = w;
        hbias_i = h;
        weight_valid_i = 1'b1;
        while (!weight_ready_o && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) timeout("weight_handshake");
        tick();
        weight_valid_i = 1'b0;
        weight_i = (N*BJ)'($urandom);
        hbias_i = BH'($urandom);
    endtask

    task automatic get_result(input bit pin, input logic [31:0] lit1, input logic [31:0] lit0,
                              input int delay, input bit noise);
        int n = 0;
        while (!energy_valid_o && n < 50) begin
            if (noise) begin
                weight_valid_i = 1'($urandom);
                spin_valid_i   = 1'($urandom);
                energy_ready_i = 1'($urandom);
            end
            tick();
            n++;
        end
        if (n >= 50) timeout("energy_valid");
        energy_ready_i = 1'b0;
        if (pin) begin
            check("literal_le1", energy_o, lit1);
            check("literal_le0", energy_b, lit0);
        end
        repeat (delay) begin
            if (noise) begin
                weight_valid_i = 1'($urandom);
                spin_valid_i   = 1'($urandom);
            end
            tick();
        end
        weight_valid_i = 1'b0;
        spin_valid_i = 1'b0;
        energy_ready_i = 1'b1;
        tick();
        energy_ready_i = 1'b0;
    endtask

    task automatic feed_rows(input wrows_t w, input hrows_t h, input gaps_t g);
        for (int r = 0; r < int'(N); r++) do_row(w[r], h[r], g[r]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_spin_ready"},   32'(spin_ready_o),   32'd0);
        check({tag, "_weight_ready"}, 32'(weight_ready_o), 32'd0);
        check({tag, "_valid"},        32'(energy_valid_o), 32'd0);
        check({tag, "_energy"},       energy_o,            32'd0);
        check({tag, "_busy"},         32'(busy_o),         32'd0);
        check({tag, "_energy_le0"},   energy_b,            32'd0);
        check({tag, "_busy_le0"},     32'(busy_b),         32'd0);
    endtask

    wrows_t w_ones  = '{16'h1111, 16'h1111, 16'h1111, 16'h1111};
    wrows_t w_zero  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    hrows_t h_zero  = '{4'h0, 4'h0, 4'h0, 4'h0};
    hrows_t h_neg8  = '{4'h8, 4'h8, 4'h8, 4'h8};
    gaps_t  g_none  = '{0, 0, 0, 0};
    gaps_t  g_split = '{0, 2, 0, 0};

    initial begin
        wrows_t wr;
        hrows_t hr;
        gaps_t  gr;

        rst_ni = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst_ni = 1'b1;
        tick();
        check("idle_spin_ready", 32'(spin_ready_o), 32'd1);

        // Case 1 with explicit latency check: valid appears after the second edge past the last row
        do_spin(4'b1111, 4'd1);
        feed_rows(w_ones, h_zero, g_none);
        check("lat_edge0", 32'(energy_valid_o), 32'd0);
        tick();
        check("lat_edge1", 32'(energy_valid_o), 32'd0);
        tick();
        check("lat_edge2", 32'(energy_valid_o), 32'd1);
        get_result(1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 0, 1'b0);

        // Case 2: mixed spins, both endian modes give -4
        do_spin(4'b0001, 4'd1);
        feed_rows(w_ones, h_zero, g_none);
        get_result(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 1'b0);

        // Case 3: bias-only energy
        do_spin(4'b1111, 4'd15);
        feed_rows(w_zero, h_neg8, g_none);
        get_result(1'b1, 32'h0000_01E0, 32'h0000_01E0, 0, 1'b0);

        // Case 4: stalled rows and a held result
        do_spin(4'b1111, 4'd1);
        feed_rows(w_ones, h_split_dummy(), g_split);
        get_result(1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 5, 1'b1);
        check("b2b_spin_ready", 32'(spin_ready_o), 32'd1);

        // Case 5: reset after two rows discards everything
        do_spin(4'b1111, 4'd15);
        do_row(16'h0000, 4'h8, 0);
        do_row(16'h0000, 4'h8, 0);
        rst_ni = 1'b0;
        tick();
        check_all_zero("midreset");
        rst_ni = 1'b1;
        tick();
        check("post_reset_spin_ready", 32'(spin_ready_o), 32'd1);
        do_spin(4'b0001, 4'd1);
        feed_rows(w_ones, h_zero, g_none);
        get_result(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 1'b0);

        // Randomized jobs
        for (int k = 0; k < 40; k++) begin
            for (int r = 0; r < int'(N); r++) begin
                wr[r] = (N*BJ)'($urandom);
                hr[r] = BH'($urandom);
                gr[r] = int'($urandom_range(0, 3));
            end
            do_spin(N'($urandom), SB'($urandom));
            feed_rows(wr, hr, gr);
            get_result(1'b0, 32'd0, 32'd0, int'($urandom_range(0, 3)), 1'b1);
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic hrows_t h_split_dummy();
        return h_zero;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
